// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner: synchronizes and debounces the
// columns, registers one hex digit per physical press and keeps the two
// most recent digits for the seven-segment multiplexer.
module keypad_scanner #(
  parameter int SCAN_CYCLES     = 4800,
  parameter int DEBOUNCE_CYCLES = 960000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic [3:0] s1,
  output logic [3:0] s2,
  output logic       key_valid,
  output logic       key_held
);

  localparam int SW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_CYCLES - 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {SCAN, DB_PRESS, HELD, DB_RELEASE} state_t;

  state_t        state, next_state;
  logic [3:0]    col_meta, col_s;
  logic [1:0]    r, next_r;
  logic [SW-1:0] scan_cnt, next_scan_cnt;
  logic [DW-1:0] db_cnt, next_db_cnt;
  logic [3:0]    key_pattern, next_key_pattern;
  logic [1:0]    key_idx, next_key_idx;
  logic          one_low;
  logic [1:0]    low_idx;
  logic          load_key;

  // Map a frozen row and column index to the printed key legend.
  function automatic logic [3:0] decode(input logic [1:0] rr, input logic [1:0] cc);
    logic [3:0] d;
    case ({rr, cc})
      4'h0: d = 4'h1;  4'h1: d = 4'h2;  4'h2: d = 4'h3;  4'h3: d = 4'hA;
      4'h4: d = 4'h4;  4'h5: d = 4'h5;  4'h6: d = 4'h6;  4'h7: d = 4'hB;
      4'h8: d = 4'h7;  4'h9: d = 4'h8;  4'hA: d = 4'h9;  4'hB: d = 4'hC;
      4'hC: d = 4'hE;  4'hD: d = 4'h0;  4'hE: d = 4'hF;  default: d = 4'hD;
    endcase
    return d;
  endfunction

  // Two-flop synchronizer for the asynchronous column inputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col_meta <= 4'hF;
      col_s    <= 4'hF;
    end else begin
      col_meta <= col;
      col_s    <= col_meta;
    end
  end

  // Recognise a single pressed column and its index; anything else is ignored.
  always_comb begin
    one_low = 1'b1;
    low_idx = 2'd0;
    case (col_s)
      4'b1110: low_idx = 2'd0;
      4'b1101: low_idx = 2'd1;
      4'b1011: low_idx = 2'd2;
      4'b0111: low_idx = 2'd3;
      default: one_low = 1'b0;
    endcase
  end

  // Next-state logic: scan rows, debounce press, wait while held, debounce release.
  always_comb begin
    next_state       = state;
    next_r           = r;
    next_scan_cnt    = scan_cnt;
    next_db_cnt      = db_cnt;
    next_key_pattern = key_pattern;
    next_key_idx     = key_idx;
    load_key         = 1'b0;
    case (state)
      SCAN: begin
        if (scan_cnt == SCAN_LAST) begin
          if (one_low) begin
            next_state       = DB_PRESS;
            next_key_pattern = col_s;
            next_key_idx     = low_idx;
            next_db_cnt      = '0;
          end else begin
            next_r        = r + 2'd1;
            next_scan_cnt = '0;
          end
        end else begin
          next_scan_cnt = scan_cnt + SW'(1);
        end
      end
      DB_PRESS: begin
        if (col_s == key_pattern) begin
          if (db_cnt == DB_LAST) begin
            load_key   = 1'b1;
            next_state = HELD;
          end else begin
            next_db_cnt = db_cnt + DW'(1);
          end
        end else begin
          next_state    = SCAN;
          next_r        = r + 2'd1;
          next_scan_cnt = '0;
          next_db_cnt   = '0;
        end
      end
      HELD: begin
        if (col_s == 4'hF) begin
          next_db_cnt = '0;
          next_state  = DB_RELEASE;
        end
      end
      default: begin
        if (col_s != 4'hF) begin
          next_state = HELD;
        end else if (db_cnt == DB_LAST) begin
          next_state    = SCAN;
          next_r        = r + 2'd1;
          next_scan_cnt = '0;
          next_db_cnt   = '0;
        end else begin
          next_db_cnt = db_cnt + DW'(1);
        end
      end
    endcase
  end

  // State, counters and the digit history registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= SCAN;
      r           <= 2'd0;
      scan_cnt    <= '0;
      db_cnt      <= '0;
      key_pattern <= 4'hF;
      key_idx     <= 2'd0;
      s1          <= 4'h0;
      s2          <= 4'h0;
      key_valid   <= 1'b0;
    end else begin
      state       <= next_state;
      r           <= next_r;
      scan_cnt    <= next_scan_cnt;
      db_cnt      <= next_db_cnt;
      key_pattern <= next_key_pattern;
      key_idx     <= next_key_idx;
      key_valid   <= load_key;
      if (load_key) begin
        s2 <= s1;
        s1 <= decode(r, key_idx);
      end
    end
  end

  assign row      = ~(4'b0001 << r);
  assign key_held = (state == HELD) || (state == DB_RELEASE);

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural 4x4 keypad model.
module tb_keypad_scanner;

  logic       clk;
  logic       reset_n;
  logic [3:0] col;
  logic [3:0] row;
  logic [3:0] s1, s2;
  logic       key_valid, key_held;

  logic [3:0] pressed [4];
  int tests_run  = 0;
  int fail_count = 0;
  int pulses     = 0;

  keypad_scanner #(.SCAN_CYCLES(4), .DEBOUNCE_CYCLES(8)) dut (
    .clk(clk), .reset_n(reset_n), .col(col), .row(row),
    .s1(s1), .s2(s2), .key_valid(key_valid), .key_held(key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad model: a pressed key pulls its column low while its row is driven.
  always_comb begin
    case (row)
      4'b1110: col = ~pressed[0];
      4'b1101: col = ~pressed[1];
      4'b1011: col = ~pressed[2];
      4'b0111: col = ~pressed[3];
      default: col = 4'hF;
    endcase
  end

  // Count every key_valid cycle, sampled away from the active edge.
  always @(negedge clk) begin
    if (reset_n && key_valid) pulses++;
  end

  // Hard stop if the sequence ever stalls.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input int budget, output logic found);
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      tick();
      if (key_valid) found = 1'b1;
    end
  endtask

  task automatic wait_row(input logic [3:0] want, input int budget, output logic found);
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      tick();
      if (row == want) found = 1'b1;
    end
  endtask

  task automatic wait_release(input int budget, output logic found);
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      tick();
      if (!key_held) found = 1'b1;
    end
  endtask

  task automatic apply_stimulus(input int rr, input logic [3:0] mask);
    pressed[rr] = mask;
  endtask

  initial begin
    logic ok;
    logic seen_row3;
    logic held_seen;
    logic [3:0] exp_row;
    int base;

    for (int i = 0; i < 4; i++) pressed[i] = 4'h0;
    reset_n = 1'b0;
    tick();
    tick();
    check_output("reset_row", row, 4'b1110);
    check_output("reset_s1", s1, 4'h0);
    check_output("reset_s2", s2, 4'h0);
    check_output("reset_valid", key_valid, 1'b0);
    check_output("reset_held", key_held, 1'b0);

    // Idle scan: each row is held for four cycles, then wraps.
    reset_n = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      exp_row = ~(4'b0001 << ((k / 4) % 4));
      check_output($sformatf("idle_row_%0d", k), row, exp_row);
    end
    check_output("idle_no_valid", pulses, 0);

    // Press "8" (row2, col1).
    apply_stimulus(2, 4'b0010);
    wait_valid(200, ok);
    check_output("k8_valid_seen", ok, 1'b1);
    check_output("k8_s1", s1, 4'h8);
    check_output("k8_s2", s2, 4'h0);
    check_output("k8_held", key_held, 1'b1);
    check_output("k8_row", row, 4'b1011);
    tick();
    check_output("k8_valid_one_cycle", key_valid, 1'b0);
    for (int i = 0; i < 20; i++) tick();
    check_output("k8_row_frozen", row, 4'b1011);
    check_output("k8_no_repeat", pulses, 1);

    // Release "8": key_held drops after 8 stable released cycles.
    apply_stimulus(2, 4'b0000);
    for (int i = 0; i < 10; i++) tick();
    check_output("k8_held_during_rel", key_held, 1'b1);
    tick();
    check_output("k8_released", key_held, 1'b0);
    check_output("k8_row_after_rel", row, 4'b0111);

    // Press and release "D" (row3, col3).
    apply_stimulus(3, 4'b1000);
    wait_valid(200, ok);
    check_output("kD_valid_seen", ok, 1'b1);
    check_output("kD_s1", s1, 4'hD);
    check_output("kD_s2", s2, 4'h8);
    apply_stimulus(3, 4'b0000);
    wait_release(100, ok);
    check_output("kD_release_seen", ok, 1'b1);
    check_output("kD_pulses", pulses, 2);

    // Press "5" (row1, col1) with a bounce: 3 low, 1 high, then stable.
    wait_row(4'b1101, 100, ok);
    check_output("k5_row1_reached", ok, 1'b1);
    apply_stimulus(1, 4'b0010);
    tick(); tick(); tick();
    apply_stimulus(1, 4'b0000);
    tick();
    apply_stimulus(1, 4'b0010);
    tick(); tick(); tick();
    check_output("k5_bounce_no_pulse", pulses, 2);
    check_output("k5_bounce_s1", s1, 4'hD);
    wait_valid(300, ok);
    check_output("k5_valid_seen", ok, 1'b1);
    check_output("k5_s1", s1, 4'h5);
    check_output("k5_s2", s2, 4'hD);

    // Add "9" while "5" is held, then release both with bounce.
    apply_stimulus(2, 4'b0100);
    for (int i = 0; i < 20; i++) tick();
    check_output("k59_no_extra", pulses, 3);
    check_output("k59_held", key_held, 1'b1);
    check_output("k59_row_frozen", row, 4'b1101);
    apply_stimulus(1, 4'b0000);
    apply_stimulus(2, 4'b0000);
    tick(); tick();
    apply_stimulus(1, 4'b0010);
    tick(); tick();
    apply_stimulus(1, 4'b0000);
    for (int i = 0; i < 10; i++) tick();
    check_output("k59_held_during_rel", key_held, 1'b1);
    tick();
    check_output("k59_released", key_held, 1'b0);
    check_output("k59_pulses", pulses, 3);
    check_output("k59_s1", s1, 4'h5);

    // Two columns low in row0 are ignored and scanning continues.
    apply_stimulus(0, 4'b0011);
    seen_row3 = 1'b0;
    held_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (row == 4'b0111) seen_row3 = 1'b1;
      if (key_held) held_seen = 1'b1;
    end
    check_output("dbl_scan_continues", seen_row3, 1'b1);
    check_output("dbl_never_held", held_seen, 1'b0);
    check_output("dbl_no_pulse", pulses, 3);
    apply_stimulus(0, 4'b0000);

    // Asynchronous reset during a press debounce of "7" (row2, col0).
    wait_row(4'b1011, 100, ok);
    check_output("k7_row2_reached", ok, 1'b1);
    apply_stimulus(2, 4'b0001);
    for (int i = 0; i < 6; i++) tick();
    check_output("k7_row_frozen", row, 4'b1011);
    base = pulses;
    #2;
    reset_n = 1'b0;
    #1;
    check_output("arst_row", row, 4'b1110);
    check_output("arst_s1", s1, 4'h0);
    check_output("arst_s2", s2, 4'h0);
    check_output("arst_held", key_held, 1'b0);
    check_output("arst_valid", key_valid, 1'b0);
    tick();
    check_output("arst_no_pulse", pulses, base);

    // Key still held after reset is detected again as a new press.
    reset_n = 1'b1;
    wait_valid(200, ok);
    check_output("k7_redetect_seen", ok, 1'b1);
    check_output("k7_s1", s1, 4'h7);
    check_output("k7_s2", s2, 4'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
    $finish;
  end

endmodule
